bucket_seed_sequencer: RTL

- Sits directly upstream of the integrity verifier on its read/write seed port.
- Supplies one (bucket version, bucket ID) seed per bucket hashed on a path, in the verifier's consumption order.
- For each accepted leaf it captures the L+1 header versions streamed from the path read.
- It then emits L+1 read-phase seeds (old version) followed by L+1 write-phase seeds (incremented version), all in root-to-leaf order.

---
 rtl/bucket_seed_sequencer.sv | 98 +++++++++
 1 files changed

// File: rtl/bucket_seed_sequencer.sv
// bucket_seed_sequencer: emits per-path read then write (version, bucket ID) seeds in root-to-leaf order
module bucket_seed_sequencer #(
    parameter int ORAML = 31,
    parameter int AESEntropy = 64
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [ORAML-1:0]      LeafIn,
    input  logic                  LeafValid,
    output logic                  LeafReady,
    input  logic [AESEntropy-1:0] HdrIV,
    input  logic                  HdrIVValid,
    output logic [AESEntropy-1:0] OutIV,
    output logic [ORAML:0]        OutBID,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic                  PathSeedsDone,
    output logic                  SeqError
);
    localparam int ORAMLogL = $clog2(ORAML + 1);
    localparam int CW = ORAMLogL + 1;
    localparam int EW = ORAMLogL + 2;
    localparam logic [CW-1:0] CapFull = CW'(ORAML + 1);
    localparam logic [EW-1:0] NumLvl = EW'(ORAML + 1);
    localparam logic [EW-1:0] LastSeed = EW'(2 * ORAML + 1);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN = 1'b1;

    logic [0:0] state;
    logic [ORAML-1:0] leaf;
    logic [AESEntropy-1:0] buffer [0:ORAML];
    logic [CW-1:0] capCnt;
    logic [EW-1:0] emitCnt, idx;
    logic [ORAMLogL-1:0] lvl;
    logic [AESEntropy-1:0] bufIV, incIV, nextIV;
    logic [ORAML:0] nextBID;
    logic xfer, isRead, eligible, capture, lastXfer, load;

    always_comb begin
        xfer = OutValid && OutReady;
        idx = emitCnt + EW'(xfer);
        isRead = idx < NumLvl;
        lvl = isRead ? ORAMLogL'(idx) : ORAMLogL'(idx - NumLvl);
        bufIV = buffer[lvl];
        incIV = bufIV + AESEntropy'(1);
        nextIV = isRead ? bufIV : (incIV == '0 ? AESEntropy'(1) : incIV);
        nextBID = ({{ORAML{1'b0}}, 1'b1} << lvl) | ({1'b0, leaf} >> (ORAMLogL'(ORAML) - lvl));
        // eligibility uses the registered capture count, so a fresh capture is seen one cycle later
        eligible = isRead ? (EW'(capCnt) > idx) : (capCnt == CapFull);
        capture = state == RUN && HdrIVValid && capCnt != CapFull;
        lastXfer = xfer && emitCnt == LastSeed;
        load = state == RUN && (!OutValid || xfer) && !lastXfer && eligible;
    end

    assign LeafReady = state == IDLE;

    always_ff @(posedge Clock)
        if (capture) buffer[capCnt[ORAMLogL-1:0]] <= HdrIV;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            leaf <= '0;
            capCnt <= '0;
            emitCnt <= '0;
            OutValid <= 1'b0;
            OutIV <= '0;
            OutBID <= '0;
            PathSeedsDone <= 1'b0;
            SeqError <= 1'b0;
        end else begin
            PathSeedsDone <= 1'b0;
            if (HdrIVValid && (state == IDLE || capCnt == CapFull)) SeqError <= 1'b1;
            if (state == IDLE) begin
                if (LeafValid) begin
                    leaf <= LeafIn;
                    capCnt <= '0;
                    emitCnt <= '0;
                    state <= RUN;
                end
            end else begin
                if (capture) capCnt <= capCnt + CW'(1);
                if (xfer) emitCnt <= emitCnt + EW'(1);
                if (lastXfer) begin
                    state <= IDLE;
                    OutValid <= 1'b0;
                    PathSeedsDone <= 1'b1;
                end else if (load) begin
                    OutValid <= 1'b1;
                    OutIV <= nextIV;
                    OutBID <= nextBID;
                end else if (xfer) begin
                    OutValid <= 1'b0;
                end
            end
        end
    end
endmodule
